// File: rtl/rx_mac_packer.sv
// ---------------------------------------------------------------------------
// rx_mac_packer
//  Packs decoded bytes from the 8b/10b decoder (PCLK rate) little-endian into
//  DataBusWidth-bit words for the MAC RX interface. The first byte received
//  lands in bits [7:0]. A single holding register carries the completed word
//  to the MAC with a valid/ready handshake.
//
//  Word boundaries: a cycle with RxValid=0, or a K character, closes any
//  partially assembled word. K characters are never packed.
//
//  Optional feature macro: PACK_FLUSH_EN
//   defined   - a partial word is emitted through the normal completion path
//               with unfilled lanes zeroed and MAC_RX_ByteEn marking only the
//               filled lanes; PartialDrop stays 0.
//   undefined - a partial word is discarded and PartialDrop pulses for one
//               cycle; MAC_RX_ByteEn is all ones whenever MAC_RX_Valid is 1.
//
//  DataBusWidth must be 8, 16 or 32.
// ---------------------------------------------------------------------------
module rx_mac_packer #(
    parameter int DataBusWidth = 32
) (
    input  logic                      PCLK,
    input  logic                      Reset,
    input  logic [7:0]                RxData,
    input  logic                      RxDataK,
    input  logic                      RxValid,
    input  logic                      RxDecodeErr,
    output logic [DataBusWidth-1:0]   MAC_RX_Data,
    output logic [DataBusWidth/8-1:0] MAC_RX_ByteEn,
    output logic                      MAC_RX_Err,
    output logic                      MAC_RX_Valid,
    input  logic                      MAC_RX_Ready,
    output logic                      Overflow,
    output logic                      PartialDrop
);

    // Bytes per word and byte-counter width (at least one bit so N==1 works).
    localparam int N     = DataBusWidth / 8;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Assembly state: byte counter and sticky decode-error flag.
    logic [CNT_W-1:0] cnt_reg;
    logic             asm_err_reg;

    // Holding register and pulse outputs.
    logic [DataBusWidth-1:0] data_reg;
    logic [N-1:0]            byte_en_reg;
    logic                    err_reg;
    logic                    valid_reg;
    logic                    overflow_reg;
    logic                    partial_drop_reg;

    // Per-cycle events derived from the decoder strobe.
    logic data_accept;      // a data (non-K) byte is taken this cycle
    logic cnt_last;         // the byte being taken fills the final lane
    logic word_complete;    // a full word leaves assembly this cycle
    logic boundary;         // idle cycle or K character closes the current word
    logic partial_pending;  // boundary reached with some lanes filled
    logic flush_partial;    // partial word goes out through the completion path
    logic drop_partial;     // partial word is thrown away
    logic word_push;        // some word heads for the holding register
    logic hold_free;        // holding register can take a word this cycle

    // Candidate word presented to the holding register.
    logic [DataBusWidth-1:0] word_data_next;
    logic [N-1:0]            word_be_next;
    logic                    word_err_next;

    assign data_accept     = RxValid && !RxDataK;
    assign cnt_last        = (cnt_reg == CNT_W'(N - 1));
    assign word_complete   = data_accept && cnt_last;
    assign boundary        = !RxValid || RxDataK;
    assign partial_pending = boundary && (cnt_reg != '0);

`ifdef PACK_FLUSH_EN
    assign flush_partial = partial_pending;
    assign drop_partial  = 1'b0;
`else
    assign flush_partial = 1'b0;
    assign drop_partial  = partial_pending;
`endif

    assign word_push = word_complete || flush_partial;
    assign hold_free = !valid_reg || MAC_RX_Ready;

    // The error of the outgoing word includes the byte arriving right now, if any.
    assign word_err_next = asm_err_reg || (data_accept && RxDecodeErr);

    // One assembly lane per byte. A lane contributes to the outgoing word when
    // it was filled earlier in this word (index below cnt) or is being filled
    // right now; other lanes read as zero so a flushed partial word is clean.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       lane_hit;
            logic       lane_filled;

            assign lane_hit    = data_accept && (cnt_reg == CNT_W'(gi));
            assign lane_filled = (CNT_W'(gi) < cnt_reg);

            // Capture the incoming data byte into this lane when it is the current one.
            always_ff @(posedge PCLK) begin
                if (Reset) begin
                    lane_reg <= '0;
                end else if (lane_hit) begin
                    lane_reg <= RxData;
                end
            end

            assign word_data_next[gi*8 +: 8] = lane_hit    ? RxData   :
                                               lane_filled ? lane_reg : 8'h00;
            assign word_be_next[gi]          = lane_hit || lane_filled;
        end
    endgenerate

    // Byte counter and error flag: advance on data bytes, restart whenever a word leaves assembly.
    always_ff @(posedge PCLK) begin
        if (Reset) begin
            cnt_reg     <= '0;
            asm_err_reg <= 1'b0;
        end else if (data_accept) begin
            if (cnt_last) begin
                cnt_reg     <= '0;
                asm_err_reg <= 1'b0;
            end else begin
                cnt_reg     <= cnt_reg + CNT_W'(1);
                asm_err_reg <= asm_err_reg || RxDecodeErr;
            end
        end else if (partial_pending) begin
            cnt_reg     <= '0;
            asm_err_reg <= 1'b0;
        end
    end

    // Holding register with valid/ready handshake plus the overflow and partial-drop pulses.
    always_ff @(posedge PCLK) begin
        if (Reset) begin
            data_reg         <= '0;
            byte_en_reg      <= '0;
            err_reg          <= 1'b0;
            valid_reg        <= 1'b0;
            overflow_reg     <= 1'b0;
            partial_drop_reg <= 1'b0;
        end else begin
            overflow_reg     <= word_push && !hold_free;
            partial_drop_reg <= drop_partial;
            if (word_push && hold_free) begin
                data_reg    <= word_data_next;
                byte_en_reg <= word_be_next;
                err_reg     <= word_err_next;
                valid_reg   <= 1'b1;
            end else if (valid_reg && MAC_RX_Ready) begin
                // Word taken with nothing new behind it: drop valid, keep the payload.
                valid_reg <= 1'b0;
            end
        end
    end

    assign MAC_RX_Data   = data_reg;
    assign MAC_RX_ByteEn = byte_en_reg;
    assign MAC_RX_Err    = err_reg;
    assign MAC_RX_Valid  = valid_reg;
    assign Overflow      = overflow_reg;
    assign PartialDrop   = partial_drop_reg;

endmodule

// File: tb/tb_rx_mac_packer.sv
// ---------------------------------------------------------------------------
// tb_rx_mac_packer
//  Drives the same byte stream into three packers (8, 16 and 32-bit words).
//  A byte-level reference model predicts every word the MAC should receive
//  and pushes it into a scoreboard queue; a monitor running on the falling
//  edge pops and compares whenever a word is handed over. Overflow,
//  PartialDrop and MAC_RX_Valid are compared every cycle. Honors
//  PACK_FLUSH_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rx_mac_packer;

    logic       PCLK;
    logic       Reset;
    logic [7:0] RxData;
    logic       RxDataK;
    logic       RxValid;
    logic       RxDecodeErr;
    logic       MAC_RX_Ready;

    // Outputs of the three instances, zero-extended to the widest format.
    logic [2:0][31:0] dat_o;
    logic [2:0][3:0]  be_o;
    logic [2:0]       err_o;
    logic [2:0]       val_o;
    logic [2:0]       ovf_o;
    logic [2:0]       pd_o;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W = 8 << gi;
            logic [W-1:0]   d;
            logic [W/8-1:0] be;
            logic           e, v, o, p;

            rx_mac_packer #(.DataBusWidth(W)) dut (
                .PCLK          (PCLK),
                .Reset         (Reset),
                .RxData        (RxData),
                .RxDataK       (RxDataK),
                .RxValid       (RxValid),
                .RxDecodeErr   (RxDecodeErr),
                .MAC_RX_Data   (d),
                .MAC_RX_ByteEn (be),
                .MAC_RX_Err    (e),
                .MAC_RX_Valid  (v),
                .MAC_RX_Ready  (MAC_RX_Ready),
                .Overflow      (o),
                .PartialDrop   (p)
            );

            assign dat_o[gi] = 32'(d);
            assign be_o[gi]  = 4'(be);
            assign err_o[gi] = e;
            assign val_o[gi] = v;
            assign ovf_o[gi] = o;
            assign pd_o[gi]  = p;
        end
    endgenerate

    // ---------------- reference model ----------------
    typedef struct {
        int          w;
        logic [31:0] d;
        logic [3:0]  be;
        logic        e;
    } exp_t;

    exp_t        expq[$];
    int          cnt_m  [3];
    logic [31:0] asm_m  [3];
    bit          aerr_m [3];
    bit          full_m [3];
    bit          eovf   [3];
    bit          epd    [3];

    task automatic check(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s width=%0d got=%h want=%h t=%0t", name, 8 << w, act, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of specification rules to width index w.
    task automatic model_step(input int w);
        int          n;
        logic [31:0] pw;
        logic [3:0]  pbe;
        logic        perr;
        bit          push;
        n    = 1 << w;
        pw   = '0;
        pbe  = '0;
        perr = 1'b0;
        push = 0;
        eovf[w] = 0;
        epd[w]  = 0;
        if (Reset) begin
            cnt_m[w]  = 0;
            asm_m[w]  = '0;
            aerr_m[w] = 0;
            full_m[w] = 0;
            for (int i = expq.size() - 1; i >= 0; i--)
                if (expq[i].w == w) expq.delete(i);
            return;
        end
        if (RxValid && !RxDataK) begin
            asm_m[w]  = asm_m[w] | (32'(RxData) << (8 * cnt_m[w]));
            aerr_m[w] = aerr_m[w] | RxDecodeErr;
            cnt_m[w]++;
            if (cnt_m[w] == n) begin
                pw   = asm_m[w];
                pbe  = 4'((1 << n) - 1);
                perr = aerr_m[w];
                push = 1;
                cnt_m[w] = 0; asm_m[w] = '0; aerr_m[w] = 0;
            end
        end else if (cnt_m[w] != 0) begin
`ifdef PACK_FLUSH_EN
            pw   = asm_m[w];
            pbe  = 4'((1 << cnt_m[w]) - 1);
            perr = aerr_m[w];
            push = 1;
`else
            epd[w] = 1;
`endif
            cnt_m[w] = 0; asm_m[w] = '0; aerr_m[w] = 0;
        end
        if (push) begin
            if (!full_m[w] || MAC_RX_Ready) begin
                expq.push_back('{w, pw, pbe, perr});
                full_m[w] = 1;
            end else begin
                eovf[w] = 1;
            end
        end else if (full_m[w] && MAC_RX_Ready) begin
            full_m[w] = 0;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model.
    task automatic step(input logic v, input logic k, input logic [7:0] d,
                        input logic e, input logic r, input logic s);
        RxValid      = v;
        RxDataK      = k;
        RxData       = d;
        RxDecodeErr  = e;
        MAC_RX_Ready = r;
        Reset        = s;
        @(posedge PCLK);
        for (int w = 0; w < 3; w++) model_step(w);
        #1;
    endtask

    task automatic byte_in(input logic [7:0] d, input logic e, input logic r);
        step(1'b1, 1'b0, d, e, r, 1'b0);
    endtask

    task automatic idle(input logic r, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'h00, 1'b0, r, 1'b0);
    endtask

    // ---------------- monitor ----------------
    task automatic monitor_width(input int w);
        int idx;
        check("valid", w, 32'(val_o[w]), 32'(full_m[w]));
        check("overflow", w, 32'(ovf_o[w]), 32'(eovf[w]));
        check("partial_drop", w, 32'(pd_o[w]), 32'(epd[w]));
        if (val_o[w] && MAC_RX_Ready && !Reset) begin
            idx = -1;
            foreach (expq[i]) if (idx < 0 && expq[i].w == w) idx = i;
            if (idx < 0) begin
                check("unexpected_word", w, dat_o[w], 32'hxxxx_xxxx);
            end else begin
                $display("word width=%0d data=%h be=%h err=%b", 8 << w, dat_o[w], be_o[w], err_o[w]);
                check("data", w, dat_o[w], expq[idx].d);
                check("byte_en", w, 32'(be_o[w]), 32'(expq[idx].be));
                check("err", w, 32'(err_o[w]), 32'(expq[idx].e));
                expq.delete(idx);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge PCLK);
            if (mon_en) for (int w = 0; w < 3; w++) monitor_width(w);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  ready_pct;
        int  left;
        logic v, k, e, r, s;
        logic [7:0] d;

        for (int w = 0; w < 3; w++) begin
            cnt_m[w] = 0; asm_m[w] = '0; aerr_m[w] = 0; full_m[w] = 0; eovf[w] = 0; epd[w] = 0;
        end

        // Reset and check the cleared output state.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            check("rst_data", w, dat_o[w], 32'h0);
            check("rst_byte_en", w, 32'(be_o[w]), 32'h0);
            check("rst_err", w, 32'(err_o[w]), 32'h0);
            check("rst_valid", w, 32'(val_o[w]), 32'h0);
            check("rst_overflow", w, 32'(ovf_o[w]), 32'h0);
            check("rst_partial_drop", w, 32'(pd_o[w]), 32'h0);
        end
        mon_en = 1;

        // Simple word with MAC always ready.
        byte_in(8'h11, 1'b0, 1'b1);
        byte_in(8'h22, 1'b0, 1'b1);
        byte_in(8'h33, 1'b0, 1'b1);
        byte_in(8'h44, 1'b0, 1'b1);
        idle(1'b1, 3);

        // MAC stalled across two completions: second word overflows.
        for (int i = 0; i < 8; i++) byte_in(8'(8'hA0 + i), 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);

        // Partial word closed by an idle cycle.
        byte_in(8'hAA, 1'b0, 1'b1);
        byte_in(8'hBB, 1'b0, 1'b1);
        idle(1'b1, 3);

        // K character between two words.
        for (int i = 0; i < 4; i++) byte_in(8'(8'h01 + i), 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) byte_in(8'(8'h05 + i), 1'b0, 1'b1);
        idle(1'b1, 3);

        // Decode error on the third byte, then a clean word.
        for (int i = 0; i < 4; i++) byte_in(8'(8'hC0 + i), (i == 2), 1'b1);
        for (int i = 0; i < 4; i++) byte_in(8'(8'hD0 + i), 1'b0, 1'b1);
        idle(1'b1, 3);

        // Reset with the holding register full and a word half assembled.
        for (int i = 0; i < 6; i++) byte_in(8'(8'hE0 + i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int w = 0; w < 3; w++) check("valid_after_reset", w, 32'(val_o[w]), 32'h0);
        for (int i = 0; i < 4; i++) byte_in(8'(8'hF0 + i), 1'b0, 1'b1);
        idle(1'b1, 3);

        // Randomized traffic with alternating MAC back-pressure.
        ready_pct = 90;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) ready_pct = (ready_pct == 90) ? 30 : 90;
            v = ($urandom_range(0, 99) < 85);
            k = ($urandom_range(0, 99) < 8);
            e = ($urandom_range(0, 99) < 10);
            r = ($urandom_range(0, 99) < ready_pct);
            s = ($urandom_range(0, 999) == 0);
            d = 8'($urandom);
            step(v, k, d, e, r, s);
        end

        // Drain and make sure every predicted word was delivered.
        idle(1'b1, 10);
        for (int w = 0; w < 3; w++) begin
            left = 0;
            foreach (expq[i]) if (expq[i].w == w) left++;
            check("words_left", w, 32'(left), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
